fetch_ctrl: RTL and testbench

- Sequencer for the instruction-fetch stage. Owns the PC register and issues requests to a variable-latency instruction memory using a req/ready handshake.
- Loads the IF/ID pipeline registers and applies downstream stalls and EX/MEM branch redirects.
- Replaces the free-running PC/incrementer path, so the fetch stage tolerates multi-cycle memory and hazard stalls.

---
 rtl/fetch_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, issues req/ready fetches to a variable-latency instruction
// memory, loads the IF/ID registers, and applies hazard stalls and EX/MEM
// branch redirects (redirect > stall > normal progress).
// Optional build macro FETCH_TIMEOUT_EN adds a wait-cycle watchdog that parks
// the block in ERROR with a sticky fetch_err after WAIT_LIMIT stalled cycles.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_MEM_PCSrc,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_npc,
  output logic        IF_ID_valid,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HOLD,
    ST_FLUSH
`ifdef FETCH_TIMEOUT_EN
    , ST_ERROR
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_addr;       // address of the request left outstanding by a redirect
  logic [31:0] r_instr;
  logic [31:0] r_npc;
  logic        r_valid;
  logic [31:0] r_buf_instr;  // word accepted while IF/ID was stalled
  logic [31:0] r_buf_npc;

  logic [31:0] w_pc_inc;
  logic        w_ld_mem;     // load IF/ID straight from memory
  logic        w_ld_buf;     // load IF/ID from the hold buffer
  logic        w_bubble;     // clear IF_ID_valid
  logic        w_buf_ld;     // capture memory data into the hold buffer
  logic        w_pc_adv;     // pc <= pc + 4
  logic        w_pc_redir;   // pc <= EX_MEM_NPC

  // pc+4 wraps modulo 2^32 with no flag
  assign w_pc_inc    = r_pc + 32'd4;

  assign pc          = r_pc;
  assign IF_ID_instr = r_instr;
  assign IF_ID_npc   = r_npc;
  assign IF_ID_valid = r_valid;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;
  logic             w_wait;
  logic             w_timeout;

  // A cycle counts as waiting whenever a request is on the bus without ready
  assign w_wait    = ((r_state == ST_FETCH) || (r_state == ST_FLUSH)) && !mem_ready;
  assign w_timeout = w_wait && (r_wait_cnt == CNT_W'(WAIT_LIMIT - 1));
  assign fetch_err = r_err;

  // Consecutive wait-cycle counter; any ready or state change restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (!w_wait || (w_state_nxt != r_state)) r_wait_cnt <= '0;
      else                                     r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;

  // WAIT_LIMIT only shapes the watchdog build; referenced here so both builds
  // accept the same parameter list without an unused-parameter report.
  if (WAIT_LIMIT == 0) begin : g_no_wait_limit
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next-state, bus outputs and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_addr    = r_pc;
    w_ld_mem    = 1'b0;
    w_ld_buf    = 1'b0;
    w_bubble    = 1'b0;
    w_buf_ld    = 1'b0;
    w_pc_adv    = 1'b0;
    w_pc_redir  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (EX_MEM_PCSrc) begin
          // Flush wins over stall; an unanswered request must be drained
          w_bubble   = 1'b1;
          w_pc_redir = 1'b1;
          if (!mem_ready) w_state_nxt = ST_FLUSH;
        end else if (stall) begin
          if (mem_ready) begin
            w_buf_ld    = 1'b1;
            w_pc_adv    = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (mem_ready) begin
          w_ld_mem = 1'b1;
          w_pc_adv = 1'b1;
        end else begin
          w_bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (EX_MEM_PCSrc) begin
          w_bubble    = 1'b1;
          w_pc_redir  = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (!stall) begin
          w_ld_buf    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FLUSH: begin
        // Keep the stale request stable until memory answers, then drop it
        mem_req  = 1'b1;
        mem_addr = r_addr;
        w_bubble = 1'b1;
        if (EX_MEM_PCSrc) w_pc_redir  = 1'b1;
        if (mem_ready)    w_state_nxt = ST_FETCH;
      end
`ifdef FETCH_TIMEOUT_EN
      ST_ERROR: begin
        w_bubble = 1'b1;
      end
`endif
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (w_timeout) begin
      w_state_nxt = ST_ERROR;
      w_bubble    = 1'b1;
      w_pc_redir  = 1'b0;
    end
`endif
  end

  // PC, outstanding address, IF/ID and hold buffer updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_instr     <= 32'h0;
      r_npc       <= 32'h0;
      r_valid     <= 1'b0;
      r_buf_instr <= 32'h0;
      r_buf_npc   <= 32'h0;
    end else begin
      if (w_pc_redir)    r_pc <= EX_MEM_NPC;
      else if (w_pc_adv) r_pc <= w_pc_inc;

      if (r_state == ST_FETCH) r_addr <= r_pc;

      if (w_ld_mem) begin
        r_instr <= mem_rdata;
        r_npc   <= w_pc_inc;
        r_valid <= 1'b1;
      end else if (w_ld_buf) begin
        r_instr <= r_buf_instr;
        r_npc   <= r_buf_npc;
        r_valid <= 1'b1;
      end else if (w_bubble) begin
        r_valid <= 1'b0;
      end

      if (w_buf_ld) begin
        r_buf_instr <= mem_rdata;
        r_buf_npc   <= w_pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed tests for the fetch sequencer.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        EX_MEM_PCSrc;
  logic [31:0] EX_MEM_NPC;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        IF_ID_valid;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .EX_MEM_PCSrc(EX_MEM_PCSrc), .EX_MEM_NPC(EX_MEM_NPC),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pc(pc), .IF_ID_instr(IF_ID_instr), .IF_ID_npc(IF_ID_npc),
    .IF_ID_valid(IF_ID_valid), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; EX_MEM_PCSrc = 1'b0; EX_MEM_NPC = 32'h0; stall = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) tick;
    n_tests++; if (pc !== 32'h0)        begin n_fail++; $display("FAIL reset_pc act=%h exp=%h", pc, 32'h0); end
    n_tests++; if (mem_addr !== 32'h0)  begin n_fail++; $display("FAIL reset_addr act=%h exp=%h", mem_addr, 32'h0); end
    n_tests++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_req act=%b exp=0", mem_req); end
    n_tests++; if (IF_ID_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr act=%h exp=0", IF_ID_instr); end
    n_tests++; if (IF_ID_npc !== 32'h0) begin n_fail++; $display("FAIL reset_npc act=%h exp=0", IF_ID_npc); end
    n_tests++; if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid act=%b exp=0", IF_ID_valid); end
    n_tests++; if (fetch_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err act=%b exp=0", fetch_err); end
  endtask

  task automatic test_zero_latency;
    mem_ready = 1'b1;
    mem_rdata = 32'h1000_0001;
    rst_n = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req act=%b exp=0", mem_req); end
    tick;
    n_tests++; if (mem_req !== 1'b1)    begin n_fail++; $display("FAIL first_req act=%b exp=1", mem_req); end
    n_tests++; if (mem_addr !== 32'h0)  begin n_fail++; $display("FAIL first_addr act=%h exp=0", mem_addr); end
    n_tests++; if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid act=%b exp=0", IF_ID_valid); end
    for (int k = 1; k <= 3; k++) begin
      mem_rdata = 32'h1000_0000 + 32'(k);
      tick;
      n_tests++; if (IF_ID_npc !== 32'(4 * k)) begin n_fail++; $display("FAIL zl_npc%0d act=%h exp=%h", k, IF_ID_npc, 32'(4 * k)); end
      n_tests++; if (IF_ID_instr !== 32'h1000_0000 + 32'(k)) begin n_fail++; $display("FAIL zl_instr%0d act=%h", k, IF_ID_instr); end
      n_tests++; if (IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL zl_valid%0d act=%b exp=1", k, IF_ID_valid); end
      n_tests++; if (pc !== 32'(4 * k)) begin n_fail++; $display("FAIL zl_pc%0d act=%h exp=%h", k, pc, 32'(4 * k)); end
    end
  endtask

  task automatic test_latency;
    mem_ready = 1'b0;
    tick;
    n_tests++; if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL lat_bubble act=%b exp=0", IF_ID_valid); end
    n_tests++; if (mem_addr !== 32'hC)   begin n_fail++; $display("FAIL lat_addr_stable act=%h exp=c", mem_addr); end
    n_tests++; if (mem_req !== 1'b1)     begin n_fail++; $display("FAIL lat_req act=%b exp=1", mem_req); end
    n_tests++; if (IF_ID_npc !== 32'hC)  begin n_fail++; $display("FAIL lat_npc_kept act=%h exp=c", IF_ID_npc); end
    mem_ready = 1'b1;
    mem_rdata = 32'h2002_0005;
    tick;
    n_tests++; if (IF_ID_instr !== 32'h2002_0005) begin n_fail++; $display("FAIL lat_instr act=%h exp=20020005", IF_ID_instr); end
    n_tests++; if (IF_ID_npc !== 32'h10)  begin n_fail++; $display("FAIL lat_npc act=%h exp=10", IF_ID_npc); end
    n_tests++; if (IF_ID_valid !== 1'b1)  begin n_fail++; $display("FAIL lat_valid act=%b exp=1", IF_ID_valid); end
    n_tests++; if (mem_addr !== 32'h10)   begin n_fail++; $display("FAIL lat_next_addr act=%h exp=10", mem_addr); end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0010;
    tick;
    n_tests++; if (mem_req !== 1'b0)     begin n_fail++; $display("FAIL hold_req act=%b exp=0", mem_req); end
    n_tests++; if (IF_ID_instr !== 32'h2002_0005) begin n_fail++; $display("FAIL hold_instr act=%h exp=20020005", IF_ID_instr); end
    n_tests++; if (pc !== 32'h14)        begin n_fail++; $display("FAIL hold_pc act=%h exp=14", pc); end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      tick;
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req%0d act=%b exp=0", c, mem_req); end
      n_tests++; if (IF_ID_npc !== 32'h10 || IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL hold_ifid%0d act=%h/%b exp=10/1", c, IF_ID_npc, IF_ID_valid); end
    end
    stall = 1'b0;
    tick;
    n_tests++; if (IF_ID_instr !== 32'hCAFE_0010) begin n_fail++; $display("FAIL rel_instr act=%h exp=cafe0010", IF_ID_instr); end
    n_tests++; if (IF_ID_npc !== 32'h14) begin n_fail++; $display("FAIL rel_npc act=%h exp=14", IF_ID_npc); end
    n_tests++; if (IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid act=%b exp=1", IF_ID_valid); end
    n_tests++; if (mem_addr !== 32'h14 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rel_addr act=%h/%b exp=14/1", mem_addr, mem_req); end
  endtask

  task automatic test_redirect;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rdata = 32'h3000_0014 + 32'(4 * k);
      tick;
    end
    mem_ready = 1'b0;
    tick;
    n_tests++; if (mem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_out_addr act=%h exp=20", mem_addr); end
    EX_MEM_PCSrc = 1'b1;
    EX_MEM_NPC = 32'h100;
    tick;
    n_tests++; if (pc !== 32'h100)      begin n_fail++; $display("FAIL rd_pc act=%h exp=100", pc); end
    n_tests++; if (mem_addr !== 32'h20 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rd_flush_addr act=%h/%b exp=20/1", mem_addr, mem_req); end
    n_tests++; if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid act=%b exp=0", IF_ID_valid); end
    EX_MEM_PCSrc = 1'b0;
    tick;
    n_tests++; if (mem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_flush_hold act=%h exp=20", mem_addr); end
    stall = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_0020;
    tick;
    n_tests++; if (mem_addr !== 32'h100 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rd_new_addr act=%h/%b exp=100/1", mem_addr, mem_req); end
    n_tests++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h3000_001C) begin n_fail++; $display("FAIL rd_discard act=%h/%b exp=3000001c/0", IF_ID_instr, IF_ID_valid); end
    stall = 1'b0;
    mem_rdata = 32'h4000_0100;
    tick;
    n_tests++; if (IF_ID_instr !== 32'h4000_0100 || IF_ID_npc !== 32'h104 || IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL rd_target act=%h/%h/%b exp=40000100/104/1", IF_ID_instr, IF_ID_npc, IF_ID_valid); end
  endtask

  task automatic test_redirect_stall;
    EX_MEM_PCSrc = 1'b1;
    EX_MEM_NPC = 32'h200;
    stall = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_0104;
    tick;
    n_tests++; if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid act=%b exp=0", IF_ID_valid); end
    n_tests++; if (pc !== 32'h200 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL rs_pc act=%h/%h exp=200/200", pc, mem_addr); end
    n_tests++; if (IF_ID_instr !== 32'h4000_0100) begin n_fail++; $display("FAIL rs_instr act=%h exp=40000100", IF_ID_instr); end
    EX_MEM_PCSrc = 1'b0;
    mem_rdata = 32'h5000_0200;
    tick;
    n_tests++; if (mem_req !== 1'b0 || pc !== 32'h204) begin n_fail++; $display("FAIL rs_hold act=%b/%h exp=0/204", mem_req, pc); end
    EX_MEM_PCSrc = 1'b1;
    EX_MEM_NPC = 32'h300;
    mem_ready = 1'b0;
    tick;
    n_tests++; if (pc !== 32'h300 || mem_addr !== 32'h300 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rh_pc act=%h/%h/%b exp=300/300/1", pc, mem_addr, mem_req); end
    n_tests++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h4000_0100) begin n_fail++; $display("FAIL rh_drop act=%h/%b exp=40000100/0", IF_ID_instr, IF_ID_valid); end
    EX_MEM_PCSrc = 1'b0;
    stall = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h6000_0300;
    tick;
    n_tests++; if (IF_ID_instr !== 32'h6000_0300 || IF_ID_npc !== 32'h304 || IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL rh_next act=%h/%h/%b exp=60000300/304/1", IF_ID_instr, IF_ID_npc, IF_ID_valid); end
  endtask

  task automatic test_wrap;
    EX_MEM_PCSrc = 1'b1;
    EX_MEM_NPC = 32'hFFFF_FFFC;
    mem_rdata = 32'h1111_1111;
    tick;
    n_tests++; if (mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr act=%h exp=fffffffc", mem_addr); end
    EX_MEM_PCSrc = 1'b0;
    mem_rdata = 32'h7000_FFFC;
    tick;
    n_tests++; if (IF_ID_npc !== 32'h0 || pc !== 32'h0) begin n_fail++; $display("FAIL wrap_npc act=%h/%h exp=0/0", IF_ID_npc, pc); end
    n_tests++; if (IF_ID_instr !== 32'h7000_FFFC || IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_instr act=%h/%b exp=7000fffc/1", IF_ID_instr, IF_ID_valid); end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0;
    repeat (15) tick;
    n_tests++; if (fetch_err !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL to_early act=%b/%b exp=0/1", fetch_err, mem_req); end
    tick;
`ifdef FETCH_TIMEOUT_EN
    n_tests++; if (fetch_err !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL to_err act=%b/%b exp=1/0", fetch_err, mem_req); end
    n_tests++; if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid act=%b exp=0", IF_ID_valid); end
    mem_ready = 1'b1;
    EX_MEM_PCSrc = 1'b1;
    EX_MEM_NPC = 32'h400;
    repeat (3) tick;
    EX_MEM_PCSrc = 1'b0;
    n_tests++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL to_sticky act=%b/%b/%h exp=1/0/0", fetch_err, mem_req, pc); end
`else
    repeat (4) tick;
    n_tests++; if (fetch_err !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL to_wait act=%b/%b/%h exp=0/1/0", fetch_err, mem_req, mem_addr); end
    mem_ready = 1'b1;
    mem_rdata = 32'h8000_0000;
    tick;
    n_tests++; if (IF_ID_npc !== 32'h4 || IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL to_done act=%h/%b exp=4/1", IF_ID_npc, IF_ID_valid); end
`endif
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || pc !== 32'h0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst act=%b/%h/%h exp=0/0/0", mem_req, pc, mem_addr); end
    n_tests++; if (IF_ID_valid !== 1'b0 || IF_ID_npc !== 32'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ifid act=%b/%h/%b exp=0/0/0", IF_ID_valid, IF_ID_npc, fetch_err); end
    tick;
  endtask

  initial begin
    test_reset;
    test_zero_latency;
    test_latency;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_wrap;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
